uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 133 +++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling FSM and a
// single-entry holding register with a valid/ready handshake toward the consumer.
module uart_rx #(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned TIMER_W      = $clog2(CLKS_PER_BIT);
    localparam logic [TIMER_W-1:0] FULL_LAST = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(CLKS_PER_BIT / 2 - 1);

    if (CLKS_PER_BIT < 4) begin : g_cpb_check
        $error("uart_rx: CLK_FREQ / BAUD_RATE must be at least 4");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rxs;
    logic [TIMER_W-1:0]   timer;
    logic [2:0]           bit_cnt;
    logic [7:0]           shift_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            timer       <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;

            // A completed byte later in this block overrides this clear.
            if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state <= START;
                        timer <= '0;
                    end
                end

                START: begin
                    if (timer == HALF_LAST) begin
                        timer   <= '0;
                        bit_cnt <= '0;
                        state   <= rxs ? IDLE : DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                DATA: begin
                    if (timer == FULL_LAST) begin
                        timer     <= '0;
                        shift_reg <= {rxs, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                STOP: begin
                    if (timer == FULL_LAST) begin
                        timer <= '0;
                        if (rxs) begin
                            state <= IDLE;
                            // Holding register is free if empty or being consumed now.
                            if (!valid_o || ready_i) begin
                                data_o  <= shift_reg;
                                valid_o <= 1'b1;
                            end else begin
                                overrun_o <= 1'b1;
                            end
                        end else begin
                            frame_err_o <= 1'b1;
                            state       <= WAIT_IDLE;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                WAIT_IDLE: begin
                    if (rxs) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
